// File: rtl/depth_sequencer.sv
// Depth-test sequencer: walks one fragment at a time through an external z-buffer,
// runs depth clears, and guards every z-buffer wait with a watchdog.
// Optional pass/fail statistics are enabled by defining DEPTH_SEQ_STATS_EN.
module depth_sequencer #(
    parameter int X_RES   = 4,
    parameter int Y_RES   = 4,
    parameter int Z_SIZE  = 8,
    parameter int TAG_W   = 16,
    parameter int TIMEOUT = 15,
    localparam int X_W    = $clog2(X_RES),
    localparam int Y_W    = $clog2(Y_RES)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              frag_valid_i,
    output logic              frag_ready_o,
    input  logic [X_W-1:0]    frag_x_i,
    input  logic [Y_W-1:0]    frag_y_i,
    input  logic [Z_SIZE-1:0] frag_z_i,
    input  logic [TAG_W-1:0]  frag_tag_i,
    input  logic [2:0]        depth_func_i,
    input  logic              depth_test_en_i,
    input  logic              clear_req_i,
    output logic              clear_busy_o,
    output logic              zb_start_o,
    output logic              zb_flush_o,
    output logic [X_W-1:0]    zb_x_o,
    output logic [Y_W-1:0]    zb_y_o,
    output logic [Z_SIZE-1:0] zb_z_o,
    output logic [2:0]        zb_func_o,
    input  logic              zb_depth_pass_i,
    input  logic              zb_flush_done_i,
    input  logic              zb_done_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [X_W-1:0]    out_x_o,
    output logic [Y_W-1:0]    out_y_o,
    output logic [TAG_W-1:0]  out_tag_o,
    output logic              timeout_err_o
`ifdef DEPTH_SEQ_STATS_EN
    ,
    output logic [31:0]       pass_cnt_o,
    output logic [31:0]       fail_cnt_o
`endif
);

    typedef enum logic [2:0] {
        IDLE, ISSUE, WAIT, RELEASE, OUTPUT, CLEAR, CLEAR_WAIT
    } state_e;

    localparam logic [3:0] WDOG_LAST = 4'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [3:0]        wdog_q, wdog_d;
    logic              pend_q, pend_d;
    logic              err_q, err_d;
    logic              pass_q, pass_d;
    logic              flush_done_q;
    logic              accept, clear_go;
    logic [X_W-1:0]    zb_x_q, out_x_q;
    logic [Y_W-1:0]    zb_y_q, out_y_q;
    logic [Z_SIZE-1:0] zb_z_q;
    logic [2:0]        zb_func_q;
    logic [TAG_W-1:0]  out_tag_q;
    logic              unused_flush_done;

    // A clear requested this very cycle already blocks the fragment, so clears win ties.
    assign frag_ready_o  = (state_q == IDLE) && !pend_q && !clear_req_i && !rst_i;
    assign clear_busy_o  = pend_q || (state_q == CLEAR) || (state_q == CLEAR_WAIT);
    assign zb_start_o    = (state_q == ISSUE) || (state_q == WAIT) ||
                           (state_q == CLEAR) || (state_q == CLEAR_WAIT);
    assign zb_flush_o    = (state_q == CLEAR) || (state_q == CLEAR_WAIT);
    assign out_valid_o   = (state_q == OUTPUT);
    assign timeout_err_o = err_q;
    assign zb_x_o        = zb_x_q;
    assign zb_y_o        = zb_y_q;
    assign zb_z_o        = zb_z_q;
    assign zb_func_o     = zb_func_q;
    assign out_x_o       = out_x_q;
    assign out_y_o       = out_y_q;
    assign out_tag_o     = out_tag_q;
    assign unused_flush_done = flush_done_q;

    always_comb begin
        state_d  = state_q;
        wdog_d   = wdog_q;
        pend_d   = pend_q || clear_req_i;
        err_d    = err_q;
        pass_d   = pass_q;
        accept   = 1'b0;
        clear_go = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend_q || clear_req_i) begin
                    state_d  = CLEAR;
                    clear_go = 1'b1;
                    pend_d   = 1'b0;
                    wdog_d   = 4'd0;
                    pass_d   = 1'b0;
                end else if (frag_valid_i) begin
                    accept = 1'b1;
                    if (depth_test_en_i) begin
                        state_d = ISSUE;
                        wdog_d  = 4'd0;
                    end else begin
                        state_d = OUTPUT;
                        pass_d  = 1'b1;
                    end
                end
            end
            ISSUE: begin
                pass_d  = zb_depth_pass_i;
                state_d = WAIT;
            end
            WAIT, CLEAR_WAIT: begin
                if (zb_done_i) begin
                    state_d = RELEASE;
                end else if (wdog_q == WDOG_LAST) begin
                    state_d = RELEASE;
                    err_d   = 1'b1;
                    pass_d  = 1'b0;
                end else begin
                    wdog_d = wdog_q + 4'd1;
                end
            end
            RELEASE: state_d = pass_q ? OUTPUT : IDLE;
            OUTPUT:  if (out_ready_i) state_d = IDLE;
            CLEAR:   state_d = CLEAR_WAIT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            wdog_q       <= 4'd0;
            pend_q       <= 1'b0;
            err_q        <= 1'b0;
            pass_q       <= 1'b0;
            flush_done_q <= 1'b0;
            zb_x_q       <= '0;
            zb_y_q       <= '0;
            zb_z_q       <= '0;
            zb_func_q    <= '0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            out_tag_q    <= '0;
        end else begin
            state_q <= state_d;
            wdog_q  <= wdog_d;
            pend_q  <= pend_d;
            err_q   <= err_d;
            pass_q  <= pass_d;
            if (clear_go)
                flush_done_q <= 1'b0;
            else if (zb_flush_o && zb_flush_done_i)
                flush_done_q <= 1'b1;
            // Operands only move on a depth-tested accept, so the z-buffer sees a quiet bus on bypass.
            if (accept && depth_test_en_i) begin
                zb_x_q    <= frag_x_i;
                zb_y_q    <= frag_y_i;
                zb_z_q    <= frag_z_i;
                zb_func_q <= depth_func_i;
            end else if (clear_go) begin
                zb_func_q <= 3'd0;
            end
            if (accept) begin
                out_x_q   <= frag_x_i;
                out_y_q   <= frag_y_i;
                out_tag_q <= frag_tag_i;
            end
        end
    end

`ifdef DEPTH_SEQ_STATS_EN
    logic [31:0] pass_cnt_q, fail_cnt_q;
    logic        frag_q;

    assign pass_cnt_o = pass_cnt_q;
    assign fail_cnt_o = fail_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pass_cnt_q <= '0;
            fail_cnt_q <= '0;
            frag_q     <= 1'b0;
        end else begin
            if (accept)
                frag_q <= depth_test_en_i;
            else if (clear_go)
                frag_q <= 1'b0;
            // Bypassed fragments never visit RELEASE, so they are counted at accept.
            if (accept && !depth_test_en_i && !(&pass_cnt_q))
                pass_cnt_q <= pass_cnt_q + 32'd1;
            if (state_q == RELEASE && frag_q) begin
                if (pass_q && !(&pass_cnt_q))
                    pass_cnt_q <= pass_cnt_q + 32'd1;
                else if (!pass_q && !(&fail_cnt_q))
                    fail_cnt_q <= fail_cnt_q + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_depth_sequencer.sv
// Directed bench for depth_sequencer: expected output fragments go into a queue,
// a negedge monitor pops and compares them on every output handshake.
module tb_depth_sequencer;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        frag_valid_i = 1'b0;
  logic        frag_ready_o;
  logic [1:0]  frag_x_i = '0;
  logic [1:0]  frag_y_i = '0;
  logic [7:0]  frag_z_i = '0;
  logic [15:0] frag_tag_i = '0;
  logic [2:0]  depth_func_i = '0;
  logic        depth_test_en_i = 1'b1;
  logic        clear_req_i = 1'b0;
  logic        clear_busy_o;
  logic        zb_start_o, zb_flush_o;
  logic [1:0]  zb_x_o, zb_y_o;
  logic [7:0]  zb_z_o;
  logic [2:0]  zb_func_o;
  logic        zb_depth_pass_i = 1'b0;
  logic        zb_flush_done_i = 1'b0;
  logic        zb_done_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic [1:0]  out_x_o, out_y_o;
  logic [15:0] out_tag_o;
  logic        timeout_err_o;
`ifdef DEPTH_SEQ_STATS_EN
  logic [31:0] pass_cnt_o, fail_cnt_o;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [19:0] exp_q[$];

  depth_sequencer dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .frag_valid_i(frag_valid_i), .frag_ready_o(frag_ready_o),
    .frag_x_i(frag_x_i), .frag_y_i(frag_y_i), .frag_z_i(frag_z_i),
    .frag_tag_i(frag_tag_i), .depth_func_i(depth_func_i),
    .depth_test_en_i(depth_test_en_i),
    .clear_req_i(clear_req_i), .clear_busy_o(clear_busy_o),
    .zb_start_o(zb_start_o), .zb_flush_o(zb_flush_o),
    .zb_x_o(zb_x_o), .zb_y_o(zb_y_o), .zb_z_o(zb_z_o), .zb_func_o(zb_func_o),
    .zb_depth_pass_i(zb_depth_pass_i), .zb_flush_done_i(zb_flush_done_i),
    .zb_done_i(zb_done_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_x_o(out_x_o), .out_y_o(out_y_o), .out_tag_o(out_tag_o),
    .timeout_err_o(timeout_err_o)
`ifdef DEPTH_SEQ_STATS_EN
    , .pass_cnt_o(pass_cnt_o), .fail_cnt_o(fail_cnt_o)
`endif
  );

  // clock
  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic present(input logic [1:0] x, input logic [1:0] y, input logic [7:0] z,
                         input logic [2:0] fn, input logic [15:0] tag, input logic test_en);
    frag_valid_i    = 1'b1;
    frag_x_i        = x;
    frag_y_i        = y;
    frag_z_i        = z;
    depth_func_i    = fn;
    frag_tag_i      = tag;
    depth_test_en_i = test_en;
  endtask

  // scoreboard monitor: every output handshake must match the head of exp_q
  always @(negedge clk_i) begin
    if (!rst_i && out_valid_o && out_ready_i) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL out_unexpected: got x=%0d y=%0d tag=0x%0h with empty queue",
                 out_x_o, out_y_o, out_tag_o);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        if ({out_x_o, out_y_o, out_tag_o} !== e) begin
          n_err++;
          $display("FAIL out_frag: got 0x%0h expected 0x%0h", {out_x_o, out_y_o, out_tag_o}, e);
        end
      end
    end
  end

  initial begin
    int n;

    // reset
    #1;
    check("ready_in_reset", frag_ready_o, 0);
    tick(); tick();
    check("rst_start", zb_start_o, 0);
    check("rst_flush", zb_flush_o, 0);
    check("rst_valid", out_valid_o, 0);
    check("rst_busy", clear_busy_o, 0);
    check("rst_err", timeout_err_o, 0);
    check("rst_zb_x", zb_x_o, 0);
    rst_i = 1'b0;
    #1;
    check("ready_after_rst", frag_ready_o, 1);

    // depth test passes, done three cycles after start
    present(2'd1, 2'd2, 8'd10, 3'd1, 16'h1234, 1'b1);
    zb_depth_pass_i = 1'b1;
    exp_q.push_back({2'd1, 2'd2, 16'h1234});
    tick();
    frag_valid_i = 1'b0;
    check("p_issue_start", zb_start_o, 1);
    check("p_zb_x", zb_x_o, 1);
    check("p_zb_y", zb_y_o, 2);
    check("p_zb_z", zb_z_o, 10);
    check("p_zb_func", zb_func_o, 1);
    check("p_ready_busy", frag_ready_o, 0);
    tick();
    check("p_wait_start", zb_start_o, 1);
    tick();
    zb_done_i = 1'b1;
    tick();
    zb_done_i = 1'b0;
    zb_depth_pass_i = 1'b0;
    check("p_release_start", zb_start_o, 0);
    check("p_release_valid", out_valid_o, 0);
    check("p_release_zb_z", zb_z_o, 10);
    tick();
    check("p_output_valid", out_valid_o, 1);
    check("p_output_start", zb_start_o, 0);
    tick();
    check("p_idle_ready", frag_ready_o, 1);

    // depth test fails: fragment dropped
    present(2'd3, 2'd1, 8'd200, 3'd1, 16'h5555, 1'b1);
    zb_depth_pass_i = 1'b0;
    tick();
    frag_valid_i = 1'b0;
    tick();
    zb_done_i = 1'b1;
    tick();
    zb_done_i = 1'b0;
    check("f_release_start", zb_start_o, 0);
    tick();
    check("f_no_valid", out_valid_o, 0);
    check("f_ready_back", frag_ready_o, 1);

    // bypass with downstream stalled four cycles
    present(2'd2, 2'd3, 8'd0, 3'd7, 16'hBEEF, 1'b0);
    out_ready_i = 1'b0;
    exp_q.push_back({2'd2, 2'd3, 16'hBEEF});
    tick();
    frag_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("b_valid_held", out_valid_o, 1);
      check("b_tag_held", out_tag_o, 16'hBEEF);
      check("b_no_start", zb_start_o, 0);
      tick();
    end
    out_ready_i = 1'b1;
    check("b_valid_5th", out_valid_o, 1);
    check("b_no_start_5th", zb_start_o, 0);
    tick();
    check("b_valid_drop", out_valid_o, 0);
    depth_test_en_i = 1'b1;

    // clear and fragment in the same IDLE cycle: clear goes first
    present(2'd3, 2'd0, 8'h80, 3'd7, 16'hA5A5, 1'b1);
    clear_req_i = 1'b1;
    zb_depth_pass_i = 1'b1;
    #1;
    check("c_ready_blocked", frag_ready_o, 0);
    tick();
    clear_req_i = 1'b0;
    check("c_flush", zb_flush_o, 1);
    check("c_start", zb_start_o, 1);
    check("c_func_never", zb_func_o, 0);
    check("c_busy", clear_busy_o, 1);
    check("c_ready_low", frag_ready_o, 0);
    tick();
    check("c_wait_flush", zb_flush_o, 1);
    zb_flush_done_i = 1'b1;
    zb_done_i = 1'b1;
    tick();
    zb_flush_done_i = 1'b0;
    zb_done_i = 1'b0;
    check("c_release_flush", zb_flush_o, 0);
    check("c_release_start", zb_start_o, 0);
    check("c_release_valid", out_valid_o, 0);
    tick();
    check("c_idle_ready", frag_ready_o, 1);
    check("c_busy_done", clear_busy_o, 0);
    exp_q.push_back({2'd3, 2'd0, 16'hA5A5});
    tick();
    frag_valid_i = 1'b0;
    check("c_frag_func", zb_func_o, 7);
    check("c_frag_x", zb_x_o, 3);
    tick();
    zb_done_i = 1'b1;
    tick();
    zb_done_i = 1'b0;
    zb_depth_pass_i = 1'b0;
    tick();
    check("c_frag_out", out_valid_o, 1);
    tick();

    // z-buffer never completes: watchdog fires
    present(2'd0, 2'd1, 8'd5, 3'd2, 16'h0F0F, 1'b1);
    zb_depth_pass_i = 1'b1;
    tick();
    frag_valid_i = 1'b0;
    tick();
    zb_depth_pass_i = 1'b0;
    n = 0;
    while (zb_start_o && n < 40) begin
      n++;
      tick();
    end
    check("t_wait_cycles", n, 15);
    check("t_err_set", timeout_err_o, 1);
    check("t_start_low", zb_start_o, 0);
    tick();
    check("t_dropped", out_valid_o, 0);
    check("t_idle_ready", frag_ready_o, 1);
    check("t_err_sticky", timeout_err_o, 1);

    // reset during WAIT with a clear pending
    present(2'd1, 2'd1, 8'd9, 3'd1, 16'h7777, 1'b1);
    zb_depth_pass_i = 1'b1;
    tick();
    frag_valid_i = 1'b0;
    tick();
    clear_req_i = 1'b1;
    check("r_wait_start", zb_start_o, 1);
    tick();
    clear_req_i = 1'b0;
    check("r_pending_busy", clear_busy_o, 1);
    rst_i = 1'b1;
    #1;
    check("r_ready_in_rst", frag_ready_o, 0);
    tick();
    check("r_start", zb_start_o, 0);
    check("r_valid", out_valid_o, 0);
    check("r_busy", clear_busy_o, 0);
    check("r_err", timeout_err_o, 0);
    check("r_zb_x", zb_x_o, 0);
    rst_i = 1'b0;
    zb_depth_pass_i = 1'b0;
    #1;
    check("r_ready_after", frag_ready_o, 1);
    tick(); tick();
    check("r_no_clear", clear_busy_o, 0);

    check("queue_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
